shared_store_sched: RTL and testbench



---
 rtl/shared_store_sched_pkg.sv | 17 +
 rtl/rr_arb2.sv | 38 +++
 rtl/shared_store_sched.sv | 151 +++++++++++++++
 tb/tb_shared_store_sched.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_store_sched_pkg.sv
// Shared types for the capture/replay backing-store scheduler.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package shared_store_sched_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Bit index of each requester in the arbiter request/grant vectors.
    typedef enum logic {
        WR = 1'b0,
        RD = 1'b1
    } side_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one grant per cycle among eligible requests.
// Latency: combinational grant; pointer updates on the following edge.
// Backpressure: a request that is not eligible is never granted.
//
// Ports: req/elig index 0 = WR side, index 1 = RD side; gnt is one-hot or zero;
// ptr names the side that wins the next contested cycle.
module rr_arb2
    import shared_store_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] elig,
    output logic [1:0] gnt,
    output side_e      ptr
);

    logic [1:0] act;

    assign act = req & elig;

    always_comb begin
        gnt = act;
        if (act == 2'b11) begin
            gnt = (ptr == WR) ? 2'b01 : 2'b10;
        end
    end

    // Only a contested cycle moves the pointer; lone grants leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= WR;
        end else if (act == 2'b11) begin
            ptr <= (ptr == WR) ? RD : WR;
        end
    end

endmodule

// File: rtl/shared_store_sched.sv
// Schedules a write port and a read port onto one single-port sync memory; zero-fills it after reset/clear.
// Latency: write issues in the handshake cycle; read data appears on out_* 2 cycles after the read handshake.
// Backpressure: out_ready low holds the result and blocks further reads; clear/INIT blocks both ports.
//
// Ports: wr_* write requester, rd_* read requester, out_* read result stream,
// clear_req re-zero pulse, busy status, mem_* external memory interface.
module shared_store_sched
    import shared_store_sched_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_valid,
    output logic          rd_ready,
    input  logic [AW-1:0] rd_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    input  logic          clear_req,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int            DEPTH = 2 ** AW;
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

    state_e        state;
    logic [AW-1:0] init_cnt;
    logic          rd_inflight;
    logic          clear_pending;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_wdata;

    logic          wr_elig;
    logic          rd_elig;
    logic [1:0]    gnt;
    logic          wr_gnt;
    logic          rd_gnt;
    side_e         rr_ptr;

    assign wr_elig = (state == RUN) && !clear_pending;
    // A read may only issue if its result slot will be free when data returns.
    assign rd_elig = wr_elig && !rd_inflight && (!out_valid || out_ready);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({rd_valid, wr_valid}),
        .elig  ({rd_elig, wr_elig}),
        .gnt   (gnt),
        .ptr   (rr_ptr)
    );

    assign wr_gnt = gnt[WR];
    assign rd_gnt = gnt[RD];

    assign wr_ready = wr_elig && !(rd_valid && rd_elig && (rr_ptr == RD));
    assign rd_ready = rd_elig && !(wr_valid && wr_elig && (rr_ptr == WR));

    assign busy = (state == INIT) || clear_pending;

    // Memory strobes are combinational so a grant reaches the memory in its
    // own cycle. Reset is folded in because INIT would otherwise strobe the
    // memory while rst_n is still low.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = last_addr;
        mem_wdata = last_wdata;
        if (!rst_n) begin
            mem_addr  = '0;
            mem_wdata = '0;
        end else if (state == INIT) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = init_cnt;
            mem_wdata = '0;
        end else if (wr_gnt) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end else if (rd_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = rd_addr;
        end
    end

    // Idle cycles replay the last address/data so the bus does not toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_addr  <= '0;
            last_wdata <= '0;
        end else if (mem_en) begin
            last_addr  <= mem_addr;
            last_wdata <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= INIT;
            init_cnt      <= '0;
            rd_inflight   <= 1'b0;
            clear_pending <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
        end else begin
            rd_inflight <= rd_gnt;

            if (rd_inflight) begin
                out_data  <= mem_rdata;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == LAST) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // clear_pending blocks new grants, so any read still in
                    // flight lands on this same edge; INIT can start next.
                    if (clear_pending) begin
                        state         <= INIT;
                        init_cnt      <= '0;
                        clear_pending <= 1'b0;
                    end else if (clear_req) begin
                        clear_pending <= 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_store_sched.sv
// Directed bench for shared_store_sched with a behavioural single-port memory.
// Latency: n/a.
// Backpressure: out_ready is driven by the stimulus process.
module tb_shared_store_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_valid, wr_ready;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_valid, rd_ready;
    logic [3:0] rd_addr;
    logic       out_valid, out_ready;
    logic [7:0] out_data;
    logic       clear_req, busy;
    logic       mem_en, mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    shared_store_sched #(.AW(4), .DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .clear_req (clear_req),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Memory starts full of 0xEE so the zero-fill is observable.
    logic [7:0] mem [16];
    logic       prefilled = 1'b0;
    always @(posedge clk) begin
        if (!prefilled) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'hEE;
            mem_rdata <= 8'h00;
            prefilled <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted result is compared to the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL out_unexpected: got data 0x%0h expected no output", out_data);
            end else begin
                chk("out_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_init(input string tag);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk({tag, "_en"},   {31'h0, mem_en}, 32'd1);
            chk({tag, "_we"},   {31'h0, mem_we}, 32'd1);
            chk({tag, "_addr"}, {28'h0, mem_addr}, i);
            chk({tag, "_wdat"}, {24'h0, mem_wdata}, 32'd0);
            chk({tag, "_wrdy"}, {31'h0, wr_ready}, 32'd0);
            chk({tag, "_busy"}, {31'h0, busy}, 32'd1);
        end
        @(negedge clk);
        chk({tag, "_done_busy"}, {31'h0, busy}, 32'd0);
        chk({tag, "_done_wrdy"}, {31'h0, wr_ready}, 32'd1);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [7:0] exp);
        logic hs = 1'b0;
        rd_addr  = a;
        rd_valid = 1'b1;
        for (int n = 0; n < 50 && !hs; n++) begin
            @(negedge clk);
            hs = rd_ready;
            if (hs) exp_q.push_back(exp);
            tick();
        end
        rd_valid = 1'b0;
        if (!hs) chk("read_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
        chk("drain_left", exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [1:0] exp_g [8];
        logic [1:0] g;
        logic       seen;
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};

        rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_valid = 1'b0; rd_addr = '0; out_ready = 1'b1; clear_req = 1'b0;

        // Reset values
        #2;
        chk("rst_busy", {31'h0, busy}, 32'd1);
        chk("rst_mem_en", {31'h0, mem_en}, 32'd0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'd0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_out_data", {24'h0, out_data}, 32'd0);
        chk("rst_rdy", {30'h0, wr_ready, rd_ready}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        check_init("init1");
        tick();

        // Write 0x5A to addr 3, then read it back on the next cycle.
        wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 8'h5A;
        @(negedge clk);
        chk("wr_ready", {31'h0, wr_ready}, 32'd1);
        chk("wr_mem", {mem_en, mem_we, 18'h0, mem_addr, mem_wdata}, {1'b1, 1'b1, 18'h0, 4'd3, 8'h5A});
        tick();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 4'd3;
        @(negedge clk);
        chk("rd_ready", {31'h0, rd_ready}, 32'd1);
        chk("rd_mem", {mem_en, mem_we, 26'h0, mem_addr}, {1'b1, 1'b0, 26'h0, 4'd3});
        exp_q.push_back(8'h5A);
        tick();
        rd_valid = 1'b0;
        @(negedge clk);
        chk("lat_t2_valid", {31'h0, out_valid}, 32'd0);
        chk("idle_mem", {mem_en, 27'h0, mem_addr}, {1'b0, 27'h0, 4'd3});
        @(negedge clk);
        chk("lat_t3_valid", {31'h0, out_valid}, 32'd1);
        chk("lat_t3_data", {24'h0, out_data}, 32'h5A);
        tick();
        drain();

        // Contested cycles: WR and RD both held high.
        wr_valid = 1'b1; wr_addr = 4'd9; wr_data = 8'h10;
        rd_valid = 1'b1; rd_addr = 4'd3;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            g = {rd_valid && rd_ready, wr_valid && wr_ready};
            chk($sformatf("grant_c%0d", c), {30'h0, g}, {30'h0, exp_g[c]});
            if (g[1]) exp_q.push_back(8'h5A);
            tick();
            if (g[0]) wr_data = wr_data + 8'h01;
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        drain();

        // Output backpressure: result held, reads blocked, then released.
        out_ready = 1'b0;
        do_read(4'd9, 8'h14);
        rd_addr = 4'd3; rd_valid = 1'b1;
        @(negedge clk);
        chk("bp_inflight_rdy", {31'h0, rd_ready}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_valid_%0d", k), {31'h0, out_valid}, 32'd1);
            chk($sformatf("bp_data_%0d", k), {24'h0, out_data}, 32'h14);
            chk($sformatf("bp_rdy_%0d", k), {31'h0, rd_ready}, 32'd0);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_rdy", {31'h0, rd_ready}, 32'd1);
        exp_q.push_back(8'h5A);
        tick();
        rd_valid = 1'b0;
        drain();

        // Clear in the same cycle as a read grant.
        rd_addr = 4'd9; rd_valid = 1'b1; clear_req = 1'b1;
        @(negedge clk);
        chk("clr_rd_rdy", {31'h0, rd_ready}, 32'd1);
        exp_q.push_back(8'h14);
        tick();
        clear_req = 1'b0; rd_valid = 1'b0;
        @(negedge clk);
        chk("clr_t1_busy", {31'h0, busy}, 32'd1);
        chk("clr_t1_en", {31'h0, mem_en}, 32'd0);
        chk("clr_t1_wrdy", {31'h0, wr_ready}, 32'd0);
        @(negedge clk);
        chk("clr_t2_init", {mem_en, mem_we, 26'h0, mem_addr}, {1'b1, 1'b1, 26'h0, 4'd0});
        seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge clk);
            seen = !busy;
        end
        chk("clr_done", {31'h0, seen}, 32'd1);
        tick();
        do_read(4'd9, 8'h00);
        do_read(4'd3, 8'h00);
        drain();

        // Reset asserted mid-INIT at init_cnt = 7.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge clk);
            seen = mem_en && mem_we && (mem_addr == 4'd7);
        end
        chk("mid_init_seen", {31'h0, seen}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_mem_en", {31'h0, mem_en}, 32'd0);
        chk("arst_mem_addr", {28'h0, mem_addr}, 32'd0);
        chk("arst_busy", {31'h0, busy}, 32'd1);
        chk("arst_out_valid", {31'h0, out_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        check_init("init2");
        tick();
        do_read(4'd3, 8'h00);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
